// File: rtl/phase_sequencer_pkg.sv
// Shared types and programme tables for the multi-phase filter sequencer.
// Each filter type selects a fixed list of system filters run back to back.
package phase_pkg;

    typedef enum logic [1:0] {
        FT_GAUSS   = 2'd0,
        FT_CANNY   = 2'd1,
        FT_EDGE4   = 2'd2,
        FT_INVALID = 2'd3
    } ft_e;

    typedef enum logic [2:0] {
        SYSF_GAUSS = 3'd0,
        SYSF_CANNY = 3'd1,
        SYSF_SOBEL = 3'd2,
        SYSF_NMS   = 3'd3,
        SYSF_HYST  = 3'd4
    } sysf_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        FILTERING,
        PHASE_DONE,
        DONE
    } state_e;

    // Unclipped programme length; zero marks an invalid type.
    function automatic int phase_count(input logic [1:0] ft);
        case (ft)
            FT_GAUSS: return 1;
            FT_CANNY: return 2;
            FT_EDGE4: return 4;
            default:  return 0;
        endcase
    endfunction

    function automatic sysf_e phase_filter(input logic [1:0] ft, input int idx);
        sysf_e f;
        f = SYSF_GAUSS;
        case (ft)
            FT_CANNY: if (idx == 1) f = SYSF_CANNY;
            FT_EDGE4: begin
                case (idx)
                    1:       f = SYSF_SOBEL;
                    2:       f = SYSF_NMS;
                    3:       f = SYSF_HYST;
                    default: f = SYSF_GAUSS;
                endcase
            end
            default:  f = SYSF_GAUSS;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Host-config and filter-engine signal bundle for phase_sequencer.
// The timeout flag only exists when PHASE_TIMEOUT_EN is defined.
interface phase_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int FT_W   = 2,
    parameter int SYSF_W = 3,
    parameter int PH_W   = 2
) ();

    logic              en_process;
    logic              abort;
    logic [FT_W-1:0]   filter_type;
    logic              filter_phase_done;
    logic [ADDR_W-1:0] source_address;
    logic [ADDR_W-1:0] final_address;
    logic [ADDR_W-1:0] temp_address_a;
    logic [ADDR_W-1:0] temp_address_b;

    logic              en_filter_phase;
    logic [SYSF_W-1:0] system_filter;
    logic [ADDR_W-1:0] input_address;
    logic [ADDR_W-1:0] output_address;
    logic [PH_W-1:0]   cur_phase;
    logic              busy;
    logic              process_done;
    logic              aborted;
`ifdef PHASE_TIMEOUT_EN
    logic              timeout;
`endif

    modport master (
        output en_process, abort, filter_type, filter_phase_done,
               source_address, final_address, temp_address_a, temp_address_b,
        input  en_filter_phase, system_filter, input_address, output_address,
               cur_phase, busy, process_done, aborted
`ifdef PHASE_TIMEOUT_EN
        , input timeout
`endif
    );

    modport slave (
        input  en_process, abort, filter_type, filter_phase_done,
               source_address, final_address, temp_address_a, temp_address_b,
        output en_filter_phase, system_filter, input_address, output_address,
               cur_phase, busy, process_done, aborted
`ifdef PHASE_TIMEOUT_EN
        , output timeout
`endif
    );

endinterface

// File: rtl/phase_sequencer_flex_counter.sv
// Generic clearable up-counter used for the phase index.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count_out <= '0;
        else if (clear)
            count_out <= '0;
        else if (count_enable)
            count_out <= count_out + 1'b1;
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase filter sequencer: walks a per-type programme, ping-ponging between temp buffers.
// Optional PHASE_TIMEOUT_EN adds a per-phase watchdog and the timeout flag.
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MAX_PHASES = 4,
    parameter int FT_W       = 2,
    parameter int SYSF_W     = 3,
    parameter int PH_W       = (MAX_PHASES > 1) ? $clog2(MAX_PHASES) : 1
`ifdef PHASE_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
    input logic              clk,
    input logic              n_rst,
    phase_sequencer_if.slave bus
);

    state_e state, next_state;

    logic [FT_W-1:0]   cfg_ft;
    logic [ADDR_W-1:0] cfg_src, cfg_final, cfg_ta, cfg_tb;

    logic [PH_W:0]     phase_cnt;
    logic [PH_W:0]     idx_next;
    int                n_phases;
    logic              last_now;
    logic              last_next;
    logic              set_abort;
    logic              phase_adv;
    logic              start_run;

    logic [SYSF_W-1:0] sysf_next;
    logic [ADDR_W-1:0] in_addr_next;
    logic [ADDR_W-1:0] out_addr_next;

`ifdef PHASE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             set_tmo;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            tmo_cnt <= '0;
        else if (state == START)
            tmo_cnt <= '0;
        else if (state == FILTERING)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == FILTERING) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    assign start_run = (state == IDLE) && bus.en_process;

    flex_counter #(.NUM_CNT_BITS(PH_W + 1)) u_phase_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (state == LOAD),
        .count_enable (phase_adv),
        .count_out    (phase_cnt)
    );

    // Configuration is frozen for the whole run on the IDLE->LOAD edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cfg_ft    <= '0;
            cfg_src   <= '0;
            cfg_final <= '0;
            cfg_ta    <= '0;
            cfg_tb    <= '0;
        end else if (start_run) begin
            cfg_ft    <= bus.filter_type;
            cfg_src   <= bus.source_address;
            cfg_final <= bus.final_address;
            cfg_ta    <= bus.temp_address_a;
            cfg_tb    <= bus.temp_address_b;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        set_abort  = 1'b0;
        phase_adv  = 1'b0;
`ifdef PHASE_TIMEOUT_EN
        set_tmo    = 1'b0;
`endif
        n_phases = phase_count(cfg_ft[1:0]);
        if (n_phases > MAX_PHASES)
            n_phases = MAX_PHASES;
        last_now = (int'(phase_cnt) == n_phases - 1);

        case (state)
            IDLE: begin
                if (bus.en_process)
                    next_state = LOAD;
            end
            LOAD: begin
                if (bus.abort || n_phases == 0) begin
                    next_state = DONE;
                    set_abort  = 1'b1;
                end else begin
                    next_state = START;
                end
            end
            START: begin
                if (bus.abort) begin
                    next_state = DONE;
                    set_abort  = 1'b1;
                end else begin
                    next_state = FILTERING;
                end
            end
            FILTERING: begin
                if (bus.abort) begin
                    next_state = DONE;
                    set_abort  = 1'b1;
                end else if (bus.filter_phase_done) begin
                    next_state = PHASE_DONE;
                end
`ifdef PHASE_TIMEOUT_EN
                else if (tmo_hit) begin
                    next_state = DONE;
                    set_abort  = 1'b1;
                    set_tmo    = 1'b1;
                end
`endif
            end
            PHASE_DONE: begin
                if (bus.abort) begin
                    next_state = DONE;
                    set_abort  = 1'b1;
                end else if (last_now) begin
                    next_state = DONE;
                end else begin
                    next_state = START;
                    phase_adv  = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Values presented with the next START pulse; the counter advances on the same edge.
        idx_next  = phase_adv ? (phase_cnt + 1'b1) : '0;
        last_next = (int'(idx_next) == n_phases - 1);
        sysf_next = SYSF_W'(phase_filter(cfg_ft[1:0], int'(idx_next)));

        if (idx_next == '0)
            in_addr_next = cfg_src;
        else if (idx_next[0])
            in_addr_next = cfg_ta;
        else
            in_addr_next = cfg_tb;

        if (last_next)
            out_addr_next = cfg_final;
        else if (!idx_next[0])
            out_addr_next = cfg_ta;
        else
            out_addr_next = cfg_tb;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.en_filter_phase <= 1'b0;
            bus.process_done    <= 1'b0;
            bus.busy            <= 1'b0;
            bus.aborted         <= 1'b0;
            bus.cur_phase       <= '0;
            bus.system_filter   <= SYSF_W'(SYSF_GAUSS);
            bus.input_address   <= '0;
            bus.output_address  <= '0;
        end else begin
            bus.en_filter_phase <= (next_state == START);
            bus.process_done    <= (next_state == DONE);
            bus.busy            <= (next_state != IDLE);
            if (start_run)
                bus.aborted <= 1'b0;
            else if (set_abort)
                bus.aborted <= 1'b1;
            if (next_state == START) begin
                bus.cur_phase      <= idx_next[PH_W-1:0];
                bus.system_filter  <= sysf_next;
                bus.input_address  <= in_addr_next;
                bus.output_address <= out_addr_next;
            end
        end
    end

`ifdef PHASE_TIMEOUT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            bus.timeout <= 1'b0;
        else if (start_run)
            bus.timeout <= 1'b0;
        else if (set_tmo)
            bus.timeout <= 1'b1;
    end
`endif

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised multi-phase filter sequencer; successor to the two-phase filter phase control in the edge-detector datapath.
- Runs a per-filter-type programme of 1..MAX_PHASES system filters.
- Ping-pongs intermediates between two temp buffers.
- Latches the configuration at start, and supports abort and an invalid-type error.
- Sits between the host/AHB config registers and the pixel filter engine.

Parameters:
ADDR_W, 32, address width.
MAX_PHASES, 4, maximum phases per programme (>=1).
FT_W, 2, filter_type width.
SYSF_W, 3, system_filter width.
PH_W, $clog2(MAX_PHASES), phase-index width.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
en_process  in  1  start request, sampled only in IDLE
abort  in  1  terminate current process
filter_type  in  FT_W  programme select
filter_phase_done  in  1  engine finished current phase
source_address  in  ADDR_W  source image base
final_address  in  ADDR_W  final output base
temp_address_a  in  ADDR_W  intermediate buffer A
temp_address_b  in  ADDR_W  intermediate buffer B
en_filter_phase  out  1  one-cycle phase start pulse
system_filter  out  SYSF_W  filter for current phase
input_address  out  ADDR_W  current phase input base
output_address  out  ADDR_W  current phase output base
cur_phase  out  PH_W  current phase index
busy  out  1  high in any non-IDLE state
process_done  out  1  one-cycle completion pulse
aborted  out  1  sticky; last run ended by abort or invalid type

Behaviour:
- All outputs registered. Reset values: en_filter_phase=0, process_done=0, busy=0, aborted=0, cur_phase=0, system_filter=SYSF_GAUSS, input_address=0, output_address=0.
- Programmes (from package table):
  - type0: GAUSS (1 phase).
  - type1: GAUSS, CANNY (2 phases).
  - type2: GAUSS, SOBEL, NMS, HYST (4 phases; clipped to MAX_PHASES).
  - type3: invalid (0 phases).
- Addressing:
  - Phase 0 input = source.
  - Phase k input = output of phase k-1.
  - Last phase output = final.
  - Non-last phase k output = temp_a if k even, else temp_b.
  - A single phase runs source -> final.
- Config latch: filter_type and all addresses are captured on the IDLE->LOAD edge. Later input changes have no effect until the next run.
- States: IDLE, LOAD, START, FILTERING, PHASE_DONE, DONE.
  - IDLE: on en_process -> LOAD; clears aborted.
  - LOAD: invalid type -> DONE with aborted=1; else -> START with phase 0.
  - START: en_filter_phase=1 this cycle only; system_filter, addresses and cur_phase are valid from this same edge; -> FILTERING.
  - FILTERING: filter_phase_done -> PHASE_DONE.
  - PHASE_DONE: if not last phase, increment cur_phase and update outputs -> START; else -> DONE.
  - DONE: process_done=1 for one cycle -> IDLE.
- Latency: en_process sampled at edge E0 -> en_filter_phase high in cycle after E1. filter_phase_done sampled at edge Ek -> next phase en_filter_phase after Ek+1; final process_done after Ek+1.
- Abort: in LOAD/START/FILTERING/PHASE_DONE -> DONE, aborted=1, process_done pulse still issued. Abort wins over a simultaneous filter_phase_done. Abort is ignored in IDLE and DONE.
- en_process while busy is ignored, with no queuing.
- filter_phase_done outside FILTERING is ignored.
- Outputs hold their last values in IDLE.
- Reset mid-run returns to IDLE with reset values immediately.

Optional Feature:
PHASE_TIMEOUT_EN.
- With the macro:
  - Adds parameter TIMEOUT_CYCLES (default 2**20) and an output port timeout (1 bit, sticky like aborted).
  - A counter runs in FILTERING and clears on START.
  - Reaching TIMEOUT_CYCLES forces DONE with timeout=1 and aborted=1.
- Without the macro: no counter, no timeout port, and FILTERING waits indefinitely.

Decomposition:
- Package phase_pkg:
  - filter_type codes FT_GAUSS/FT_CANNY/FT_EDGE4/FT_INVALID;
  - system filter codes SYSF_GAUSS/CANNY/SOBEL/NMS/HYST;
  - state enum;
  - function phase_count(ft);
  - function phase_filter(ft, idx).
- Phase index sub-module: reuse existing flex_counter at PH_W+1 bits; clear on LOAD, count_enable on PHASE_DONE->START.
- Address and filter selection stays inline.

Test Plan:
- Reset, then idle 5 cycles -> all outputs at reset values; busy=0.
- type0, src=0x1000, final=0x2000, done after 10 cycles -> one en_filter_phase pulse with GAUSS, 0x1000->0x2000; process_done 2 cycles after done.
- type1, tempA=0x3000 -> phase0 GAUSS 0x1000->0x3000; phase1 CANNY 0x3000->0x2000; exactly two pulses.
- type2, tempB=0x4000, MAX_PHASES=4 -> A/B/final chain: src->A, A->B, B->A, A->final; filters GAUSS, SOBEL, NMS, HYST; cur_phase 0..3.
- Abort asserted together with filter_phase_done in phase1 of type2 -> no phase2 pulse; process_done pulse; aborted=1. Next run clears aborted.
- type3 -> no en_filter_phase; process_done 2 cycles after start; aborted=1. en_process pulsed while busy in another run -> ignored.
